add_sub: RTL and testbench

ADD_SUB -- requirements
Module: add_sub

---
 rtl/fp_pkg.sv | 18 +
 rtl/lzc24.sv | 19 +
 rtl/add_sub.sv | 140 ++++++++++++++
 tb/tb_add_sub.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision float constants and unpacked-float view.
// Imported by the add_sub datapath and its helpers.
package fp_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

endpackage

// File: rtl/lzc24.sv
// 24-bit leading-zero counter; lz = 24 when din is all zero.
// Ports: din[23:0] in, lz[4:0] out.
module lzc24 (
  input  logic [23:0] din,
  input  logic        unused_tie,
  output logic [4:0]  lz
);

  logic unused;
  assign unused = unused_tie;

  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) lz = 5'(23 - i);
    end
  end

endmodule

// File: rtl/add_sub.sv
// Single-cycle IEEE-754 single-precision adder/subtractor, RNE.
// Ports: clk, n_rst (sync, high), add_start, mode, op1, op2 -> add_result, add_done, add_overflow.
module add_sub
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        add_start,
  input  logic        mode,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] add_result,
  output logic        add_done,
  output logic        add_overflow
);

  fp_t x, y;
  logic sx, sy, sa, sb, swap;
  logic [7:0] ea, eb, diff;
  logic [23:0] ma, mb;
  logic [49:0] b_sh;
  logic [26:0] a_al, b_al, d;
  logic [27:0] sum;
  logic [4:0] lz;

  assign x = op1;
  assign y = op2;
  assign sx = x.sign;
  // Subtraction is addition with op2's sign flipped.
  assign sy = y.sign ^ mode;

  always_comb begin
    swap = op2[30:0] > op1[30:0];
    sa   = swap ? sy : sx;
    sb   = swap ? sx : sy;
    ea   = swap ? y.exp : x.exp;
    eb   = swap ? x.exp : y.exp;
    ma   = swap ? {1'b1, y.frac} : {1'b1, x.frac};
    mb   = swap ? {1'b1, x.frac} : {1'b1, y.frac};
    diff = ea - eb;
    b_sh = {mb, 26'd0} >> diff;
    // Low 3 bits are guard, round, sticky.
    if (diff >= 8'd26) b_al = 27'd1;
    else b_al = {b_sh[49:24], |b_sh[23:0]};
    a_al = {ma, 3'b000};
    sum  = {1'b0, a_al} + {1'b0, b_al};
    d    = a_al - b_al;
  end

  lzc24 u_lzc (
    .din        (d[26:3]),
    .unused_tie (sb),
    .lz         (lz)
  );

  logic [26:0] m;
  logic [9:0]  e;
  logic [24:0] rsig;
  logic [23:0] sig;
  logic        up;
  logic        nan_x, nan_y, inf_x, inf_y;
  logic        zero_x, zero_y;
  logic [31:0] res_c;
  logic        ovf_c;

  always_comb begin
    m = '0;
    e = '0;
    if (sa == sb) begin
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = {2'b00, ea} + 10'd1;
      end else begin
        m = sum[26:0];
        e = {2'b00, ea};
      end
    end else begin
      m = d << lz;
      e = {2'b00, ea} - {5'd0, lz};
    end
    up   = m[2] & (m[1] | m[0] | m[3]);
    rsig = {1'b0, m[26:3]} + {24'd0, up};
    if (rsig[24]) begin
      sig = rsig[24:1];
      e   = e + 10'd1;
    end else begin
      sig = rsig[23:0];
    end
  end

  always_comb begin
    nan_x  = (x.exp == EXP_MAX) && (x.frac != '0);
    nan_y  = (y.exp == EXP_MAX) && (y.frac != '0);
    inf_x  = (x.exp == EXP_MAX) && (x.frac == '0);
    inf_y  = (y.exp == EXP_MAX) && (y.frac == '0);
    zero_x = (x.exp == '0);
    zero_y = (y.exp == '0);
    res_c  = '0;
    ovf_c  = 1'b0;
    if (nan_x || nan_y) begin
      res_c = QNAN;
    end else if (inf_x && inf_y) begin
      res_c = (sx != sy) ? QNAN : {sx, EXP_MAX, 23'd0};
    end else if (inf_x) begin
      res_c = {sx, EXP_MAX, 23'd0};
    end else if (inf_y) begin
      res_c = {sy, EXP_MAX, 23'd0};
    end else if (zero_x && zero_y) begin
      res_c = {sx & sy, 31'd0};
    end else if (zero_y) begin
      res_c = {sx, op1[30:0]};
    end else if (zero_x) begin
      res_c = {sy, op2[30:0]};
    end else if (sa != sb && d == '0) begin
      res_c = '0;
    end else if ($signed(e) >= 10'sd255) begin
      res_c = {sa, EXP_MAX, 23'd0};
      ovf_c = 1'b1;
    end else if ($signed(e) <= 10'sd0) begin
      res_c = {sa, 31'd0};
    end else begin
      res_c = {sa, e[7:0], sig[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      add_result   <= '0;
      add_done     <= 1'b0;
      add_overflow <= 1'b0;
    end else begin
      add_done <= add_start;
      if (add_start) begin
        add_result   <= res_c;
        add_overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed and random ops
// against an exact wide-integer reference with RNE rounding.
module tb_add_sub;

  logic        clk;
  logic        n_rst;
  logic        add_start;
  logic        mode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] add_result;
  logic        add_done;
  logic        add_overflow;

  add_sub dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .add_start    (add_start),
    .mode         (mode),
    .op1          (op1),
    .op2          (op2),
    .add_result   (add_result),
    .add_done     (add_done),
    .add_overflow (add_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        exp_done;
  logic [31:0] exp_res;
  logic        exp_ovf;
  logic [31:0] last_a, last_b;
  logic        last_m;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got %h expected %h (op1 %h op2 %h mode %0d)",
                  tag, got, want, last_a, last_b, last_m);
  endtask

  // Exact value of each operand as an integer scaled to the
  // smaller exponent, summed, then rounded to 24 bits RNE.
  function automatic logic [32:0] ref_model(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic m);
    logic sa, sb, s;
    int ea, eb, emin, p, sh, e;
    logic [22:0] fa, fb;
    logic [319:0] ua, ub, mag, keep, rem, half, mask;
    sa = a[31];
    sb = b[31] ^ m;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))
      return {1'b0, 32'h7FC00000};
    if (ea == 255 && eb == 255)
      return (sa != sb) ? {1'b0, 32'h7FC00000}
                        : {1'b0, sa, 8'hFF, 23'd0};
    if (ea == 255) return {1'b0, sa, 8'hFF, 23'd0};
    if (eb == 255) return {1'b0, sb, 8'hFF, 23'd0};
    if (ea == 0 && eb == 0) return {1'b0, sa & sb, 31'd0};
    if (ea == 0) emin = eb;
    else if (eb == 0) emin = ea;
    else emin = (ea < eb) ? ea : eb;
    ua = '0;
    ub = '0;
    if (ea != 0) ua = {296'd0, 1'b1, fa} << (ea - emin);
    if (eb != 0) ub = {296'd0, 1'b1, fb} << (eb - emin);
    if (sa == sb) begin
      mag = ua + ub; s = sa;
    end else if (ua > ub) begin
      mag = ua - ub; s = sa;
    end else if (ub > ua) begin
      mag = ub - ua; s = sb;
    end else begin
      return {1'b0, 32'd0};
    end
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = emin + p - 23;
    if (p <= 23) begin
      keep = mag << (23 - p);
    end else begin
      sh   = p - 23;
      keep = mag >> sh;
      mask = (320'd1 << sh) - 320'd1;
      rem  = mag & mask;
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 320'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        e++;
      end
    end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    return {1'b0, s, 8'(e), keep[22:0]};
  endfunction

  // Check outputs produced by the previous edge, then drive the next cycle.
  task automatic step(input logic rst, input logic st,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic m);
    logic [32:0] r;
    @(negedge clk);
    check("done", {31'd0, add_done}, {31'd0, exp_done});
    check("result", add_result, exp_res);
    check("overflow", {31'd0, add_overflow}, {31'd0, exp_ovf});
    n_rst     = rst;
    add_start = st;
    op1       = a;
    op2       = b;
    mode      = m;
    if (rst) begin
      exp_done = 1'b0;
      exp_res  = '0;
      exp_ovf  = 1'b0;
    end else begin
      exp_done = st;
      if (st) begin
        r       = ref_model(a, b, m);
        exp_res = r[31:0];
        exp_ovf = r[32];
        last_a  = a;
        last_b  = b;
        last_m  = m;
      end
    end
  endtask

  function automatic logic [31:0] gen_fp();
    logic [31:0] v;
    int k;
    v = $urandom();
    k = $urandom_range(0, 19);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v = {v[31], 8'hFF, v[0] ? 23'd0 : v[22:0]};
    else if (k <= 4) v[30:23] = 8'($urandom_range(240, 254));
    else if (k <= 7) v[30:23] = 8'($urandom_range(1, 30));
    else if (k <= 18) v[30:23] = 8'($urandom_range(1, 254));
    return v;
  endfunction

  function automatic logic [31:0] gen_near(input logic [31:0] a);
    logic [31:0] v;
    int e, k;
    v = $urandom();
    k = $urandom_range(0, 5);
    e = int'(a[30:23]);
    if (k == 0) return {v[31], a[30:0]};
    if (k <= 2) e = e + $urandom_range(0, 6) - 3;
    else if (k == 3) e = e - $urandom_range(20, 30);
    else e = e + $urandom_range(0, 2) - 1;
    if (k == 4) v[22:0] = a[22:0] ^ (23'd1 << $urandom_range(0, 22));
    if (e < 1) e = 1;
    if (e > 254) e = 254;
    v[30:23] = 8'(e);
    return v;
  endfunction

  initial begin
    logic [31:0] a, b;
    n_rst     = 1'b1;
    add_start = 1'b0;
    mode      = 1'b0;
    op1       = '0;
    op2       = '0;
    last_a    = '0;
    last_b    = '0;
    last_m    = 1'b0;
    exp_done  = 1'b0;
    exp_res   = '0;
    exp_ovf   = 1'b0;
    repeat (2) @(posedge clk);

    step(0, 1, 32'h41480000, 32'h418C0000, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    step(0, 1, 32'h40840000, 32'hC0800000, 0);
    step(0, 1, 32'hC0800000, 32'h40840000, 0);
    step(0, 1, 32'h41200000, 32'hC0A00000, 0);
    step(0, 1, 32'h40200000, 32'h40200000, 1);
    step(0, 1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    step(0, 1, 32'h3F800000, 32'h3F800000, 0);
    step(0, 1, 32'h7F800000, 32'h7F800000, 1);
    step(0, 1, 32'h7F800000, 32'h7F800000, 0);
    step(0, 1, 32'h7FC00001, 32'h3F800000, 0);
    step(0, 1, 32'h80000000, 32'h00000000, 1);
    step(0, 1, 32'h80000000, 32'h00000000, 0);
    step(0, 1, 32'h3F800000, 32'h3F7FFFFF, 1);
    step(0, 1, 32'h00800000, 32'h00800001, 1);
    step(0, 1, 32'h4B800000, 32'h3F800000, 0);
    step(0, 1, 32'h3F800001, 32'h00400000, 0);
    step(1, 1, 32'h41480000, 32'h418C0000, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    step(0, 1, 32'h41480000, 32'h418C0000, 1);

    for (int i = 0; i < 4000; i++) begin
      a = gen_fp();
      b = ($urandom_range(0, 1) == 1) ? gen_near(a) : gen_fp();
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
           a, b, 1'($urandom_range(0, 1)));
    end
    step(0, 0, 32'h0, 32'h0, 0);
    step(0, 0, 32'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
